// File: rtl/fast_pkg.sv
// Shared constants, types and helpers for the FAST corner detector.
package fast_pkg;

    localparam int unsigned PIXEL_WIDTH_DEF = 8;
    localparam int unsigned CIRCLE_N        = 16;
    localparam int unsigned SCORE_W         = 12;
    localparam int unsigned COORD_W         = 20;
    localparam int unsigned SCORE_MAX       = 4095;

    // Bresenham-16 ring offsets (dx, dy) from the window centre, k=0 at the top, clockwise.
    localparam int RING_DX [CIRCLE_N] = '{0, 1, 2, 3, 3, 3, 2, 1, 0, -1, -2, -3, -3, -3, -2, -1};
    localparam int RING_DY [CIRCLE_N] = '{-3, -3, -2, -1, 0, 1, 2, 3, 3, 3, 2, 1, 0, -1, -2, -3};

    // FIFO payload when scoring is built in.
    typedef struct packed {
        logic [COORD_W-1:0] xy;
        logic [SCORE_W-1:0] score;
    } corner_t;

    // True when mask holds len or more circularly contiguous ones.
    function automatic logic has_arc(input logic [CIRCLE_N-1:0] mask, input int unsigned len);
        logic       found;
        logic       run;
        logic [3:0] idx;
        found = 1'b0;
        for (int s = 0; s < int'(CIRCLE_N); s++) begin
            run = 1'b1;
            for (int j = 0; j < int'(CIRCLE_N); j++) begin
                idx = 4'((s + j) % 16);
                if (j < int'(len)) begin
                    run = run & mask[idx];
                end
            end
            found = found | run;
        end
        return found;
    endfunction

endpackage

// File: rtl/fast_corner_fifo.sv
// Synchronous corner FIFO with a registered head entry and registered full/empty flags.
module fast_corner_fifo #(
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push_i,
    input  logic              pop_i,
    input  logic [DATA_W-1:0] data_i,
    output logic [DATA_W-1:0] head_o,
    output logic              empty_o,
    output logic              full_o
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [DATA_W-1:0] head_q, head_d;
    logic              empty_q, full_q;
    logic              do_push, do_pop;

    // Pointer, occupancy and head-entry next state; a full FIFO accepts a push only alongside a pop.
    always_comb begin
        do_pop  = pop_i & ~empty_q;
        do_push = push_i & (~full_q | do_pop);
        wr_d    = do_push ? wr_q + AW'(1) : wr_q;
        rd_d    = do_pop  ? rd_q + AW'(1) : rd_q;
        cnt_d   = cnt_q + CW'(do_push) - CW'(do_pop);
        head_d  = head_q;
        if (do_push && ((cnt_q - CW'(do_pop)) == '0)) begin
            head_d = data_i;
        end else if (do_pop) begin
            head_d = mem_q[rd_d];
        end
    end

    // Storage array; no reset needed since occupancy gates every read.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_q] <= data_i;
        end
    end

    // Control and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q    <= '0;
            rd_q    <= '0;
            cnt_q   <= '0;
            head_q  <= '0;
            empty_q <= 1'b1;
            full_q  <= 1'b0;
        end else begin
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            cnt_q   <= cnt_d;
            head_q  <= head_d;
            empty_q <= (cnt_d == '0);
            full_q  <= (cnt_d == CW'(DEPTH));
        end
    end

    assign head_o  = head_q;
    assign empty_o = empty_q;
    assign full_o  = full_q;

endmodule

// File: rtl/fast_corner_detect.sv
// FAST corner detector: classify -> arc detect -> score/commit, then a corner FIFO.
// Build option FAST_SCORE_EN adds the corner score; without it corner_score is 0.
module fast_corner_detect
    import fast_pkg::*;
#(
    parameter int unsigned PIXEL_WIDTH = PIXEL_WIDTH_DEF,
    parameter int unsigned ARC_LEN     = 9,
    parameter int unsigned FIFO_DEPTH  = 16
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            ce,
    input  logic                            patch_vld,
    input  logic [CIRCLE_N*PIXEL_WIDTH-1:0] circle,
    input  logic [PIXEL_WIDTH-1:0]          center,
    input  logic [PIXEL_WIDTH-1:0]          threshold,
    input  logic [COORD_W-1:0]              xy_in,
    input  logic                            sof,
    output logic                            corner_vld,
    input  logic                            corner_rdy,
    output logic [COORD_W-1:0]              corner_xy,
    output logic [SCORE_W-1:0]              corner_score,
    output logic [15:0]                     frame_corners,
    output logic [15:0]                     overflow_cnt
);

    localparam int unsigned EW = PIXEL_WIDTH + 2;
`ifdef FAST_SCORE_EN
    localparam int unsigned ENTRY_W = COORD_W + SCORE_W;
    localparam int unsigned SUM_W   = (PIXEL_WIDTH + 4 > SCORE_W + 1) ? PIXEL_WIDTH + 4 : SCORE_W + 1;
`else
    localparam int unsigned ENTRY_W = COORD_W;
`endif

    logic [CIRCLE_N-1:0] bright_d, dark_d;
    logic [EW-1:0]       c_e, hi_e, lo_e, t_e, pix_e;
    logic                corner_d;

    logic                s1_vld_q, s2_vld_q, s3_vld_q;
    logic [COORD_W-1:0]  s1_xy_q, s2_xy_q, s3_xy_q;
    logic [CIRCLE_N-1:0] s1_bright_q, s1_dark_q;
    logic                s2_corner_q, s3_corner_q;

    logic                push, drop, fifo_empty, fifo_full;
    logic [ENTRY_W-1:0]  push_entry, fifo_head;
    logic [15:0]         frame_q, frame_d, ovf_q, ovf_d;

    // Stage-1 classification in widened arithmetic so centre +/- t never wraps.
    always_comb begin
        bright_d = '0;
        dark_d   = '0;
        pix_e    = '0;
        c_e      = EW'(center);
        t_e      = EW'(threshold);
        hi_e     = c_e + t_e;
        lo_e     = c_e - t_e;
        for (int k = 0; k < int'(CIRCLE_N); k++) begin
            pix_e       = EW'(circle[k*PIXEL_WIDTH +: PIXEL_WIDTH]);
            bright_d[k] = (pix_e > hi_e);
            dark_d[k]   = (c_e >= t_e) && (pix_e < lo_e);
        end
    end

    // Stage-2 corner flag from either contiguous arc.
    always_comb begin
        corner_d = has_arc(s1_bright_q, ARC_LEN) | has_arc(s1_dark_q, ARC_LEN);
    end

    // Pipeline stage registers, advancing only on ce.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld_q    <= 1'b0;
            s2_vld_q    <= 1'b0;
            s3_vld_q    <= 1'b0;
            s1_xy_q     <= '0;
            s2_xy_q     <= '0;
            s3_xy_q     <= '0;
            s1_bright_q <= '0;
            s1_dark_q   <= '0;
            s2_corner_q <= 1'b0;
            s3_corner_q <= 1'b0;
        end else if (ce) begin
            s1_vld_q    <= patch_vld;
            s2_vld_q    <= s1_vld_q;
            s3_vld_q    <= s2_vld_q;
            s1_xy_q     <= xy_in;
            s2_xy_q     <= s1_xy_q;
            s3_xy_q     <= s2_xy_q;
            s1_bright_q <= bright_d;
            s1_dark_q   <= dark_d;
            s2_corner_q <= corner_d;
            s3_corner_q <= s2_corner_q;
        end
    end

`ifdef FAST_SCORE_EN
    logic [CIRCLE_N*PIXEL_WIDTH-1:0] exc_d, s1_exc_q, s2_exc_q;
    logic [PIXEL_WIDTH-1:0]          pix, diff;
    logic [SUM_W-1:0]                sum;
    logic [SCORE_W-1:0]              score_d, s3_score_q;
    corner_t                         head_entry;

    // Per-pixel excess max(|p-c|-t, 0), computed alongside classification.
    always_comb begin
        exc_d = '0;
        pix   = '0;
        diff  = '0;
        for (int k = 0; k < int'(CIRCLE_N); k++) begin
            pix  = circle[k*PIXEL_WIDTH +: PIXEL_WIDTH];
            diff = (pix > center) ? pix - center : center - pix;
            exc_d[k*PIXEL_WIDTH +: PIXEL_WIDTH] = (diff > threshold) ? diff - threshold : '0;
        end
    end

    // Stage-3 adder tree with saturation to the score width.
    always_comb begin
        sum = '0;
        for (int k = 0; k < int'(CIRCLE_N); k++) begin
            sum = sum + SUM_W'(s2_exc_q[k*PIXEL_WIDTH +: PIXEL_WIDTH]);
        end
        score_d = (sum > SUM_W'(SCORE_MAX)) ? SCORE_W'(SCORE_MAX) : SCORE_W'(sum);
    end

    // Score path registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_exc_q   <= '0;
            s2_exc_q   <= '0;
            s3_score_q <= '0;
        end else if (ce) begin
            s1_exc_q   <= exc_d;
            s2_exc_q   <= s1_exc_q;
            s3_score_q <= score_d;
        end
    end

    assign push_entry   = {s3_xy_q, s3_score_q};
    assign head_entry   = fifo_head;
    assign corner_xy    = head_entry.xy;
    assign corner_score = head_entry.score;
`else
    assign push_entry   = s3_xy_q;
    assign corner_xy    = fifo_head;
    assign corner_score = '0;
`endif

    assign push = ce & s3_vld_q & s3_corner_q;
    assign drop = push & fifo_full & ~(corner_rdy & ~fifo_empty);

    fast_corner_fifo #(
        .DEPTH  (FIFO_DEPTH),
        .DATA_W (ENTRY_W)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .pop_i   (corner_rdy),
        .data_i  (push_entry),
        .head_o  (fifo_head),
        .empty_o (fifo_empty),
        .full_o  (fifo_full)
    );

    // Frame and overflow counters; sof restarts the frame count, including a coincident corner.
    always_comb begin
        frame_d = frame_q;
        ovf_d   = ovf_q;
        if (sof) begin
            frame_d = push ? 16'd1 : 16'd0;
        end else if (push && (frame_q != 16'hFFFF)) begin
            frame_d = frame_q + 16'd1;
        end
        if (drop && (ovf_q != 16'hFFFF)) begin
            ovf_d = ovf_q + 16'd1;
        end
    end

    // Counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_q <= '0;
            ovf_q   <= '0;
        end else begin
            frame_q <= frame_d;
            ovf_q   <= ovf_d;
        end
    end

    assign corner_vld    = ~fifo_empty;
    assign frame_corners = frame_q;
    assign overflow_cnt  = ovf_q;

endmodule

// File: tb/tb_fast_corner_detect.sv
// Scoreboard bench for fast_corner_detect (default parameters; honours FAST_SCORE_EN).
module tb_fast_corner_detect;

    localparam int unsigned PW = 8;

`ifdef FAST_SCORE_EN
    localparam logic [11:0] S1 = 12'd90;
    localparam logic [11:0] S2 = 12'd270;
`else
    localparam logic [11:0] S1 = 12'd0;
    localparam logic [11:0] S2 = 12'd0;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          ce;
    logic          patch_vld;
    logic [16*PW-1:0] circle;
    logic [PW-1:0] center;
    logic [PW-1:0] threshold;
    logic [19:0]   xy_in;
    logic          sof;
    logic          corner_vld;
    logic          corner_rdy;
    logic [19:0]   corner_xy;
    logic [11:0]   corner_score;
    logic [15:0]   frame_corners;
    logic [15:0]   overflow_cnt;

    typedef struct packed {
        logic [19:0] xy;
        logic [11:0] score;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_vec = 0;
    int   n_err = 0;

    fast_corner_detect dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .ce            (ce),
        .patch_vld     (patch_vld),
        .circle        (circle),
        .center        (center),
        .threshold     (threshold),
        .xy_in         (xy_in),
        .sof           (sof),
        .corner_vld    (corner_vld),
        .corner_rdy    (corner_rdy),
        .corner_xy     (corner_xy),
        .corner_score  (corner_score),
        .frame_corners (frame_corners),
        .overflow_cnt  (overflow_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [16*PW-1:0] mk_ring(input logic [15:0] mask, input logic [PW-1:0] on_v,
                                                 input logic [PW-1:0] off_v);
        logic [16*PW-1:0] r;
        r = '0;
        for (int k = 0; k < 16; k++) begin
            r[k*PW +: PW] = mask[k] ? on_v : off_v;
        end
        return r;
    endfunction

    // One window, sampled on the next edge; the expected FIFO entry is queued at issue time.
    task automatic send(input logic [15:0] mask, input logic [PW-1:0] on_v, input logic [PW-1:0] off_v,
                        input logic [PW-1:0] c, input logic [PW-1:0] t, input logic [19:0] xy,
                        input bit exp_push, input logic [11:0] score);
        circle    = mk_ring(mask, on_v, off_v);
        center    = c;
        threshold = t;
        xy_in     = xy;
        patch_vld = 1'b1;
        ce        = 1'b1;
        if (exp_push) exp_q.push_back(exp_t'{xy: xy, score: score});
        step();
        patch_vld = 1'b0;
    endtask

    // Monitor: every handshake pops the scoreboard and compares the head entry.
    always @(negedge clk) begin
        if (rst_n && corner_vld && corner_rdy) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_pop: got xy 0x%0h, expected no entry", corner_xy);
            end else begin
                mon_e = exp_q.pop_front();
                check("pop_xy", 32'(corner_xy), 32'(mon_e.xy));
                check("pop_score", 32'(corner_score), 32'(mon_e.score));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; ce = 1'b0; patch_vld = 1'b0; sof = 1'b0; corner_rdy = 1'b0;
        circle = '0; center = '0; threshold = '0; xy_in = '0;
        repeat (2) step();
        check("rst_vld", 32'(corner_vld), 32'd0);
        check("rst_xy", 32'(corner_xy), 32'd0);
        check("rst_score", 32'(corner_score), 32'd0);
        check("rst_frame", 32'(frame_corners), 32'd0);
        check("rst_ovf", 32'(overflow_cnt), 32'd0);
        rst_n = 1'b1;
        ce    = 1'b1;
        step();

        // Bright arc k=0..8, latency of three ce-cycles to the FIFO.
        send(16'h01FF, 8'd130, 8'd100, 8'd100, 8'd20, 20'h0A00B, 1'b1, S1);
        step(); step();
        check("lat_early_vld", 32'(corner_vld), 32'd0);
        step();
        check("lat_vld", 32'(corner_vld), 32'd1);
        check("lat_xy", 32'(corner_xy), 32'h0A00B);
        check("lat_score", 32'(corner_score), 32'(S1));
        corner_rdy = 1'b1;
        step();
        check("lat_drained", 32'(corner_vld), 32'd0);

        // Wrapped dark arc (9 pixels), 8-pixel arc, low-centre and high-centre rings back to back.
        send(16'hF01F, 8'd50, 8'd100, 8'd100, 8'd20, 20'h12345, 1'b1, S2);
        send(16'hF00F, 8'd50, 8'd100, 8'd100, 8'd20, 20'h00001, 1'b0, 12'd0);
        send(16'h0000, 8'd0,  8'd0,   8'd10,  8'd20, 20'h00002, 1'b0, 12'd0);
        send(16'hFFFF, 8'd255, 8'd255, 8'd250, 8'd20, 20'h00003, 1'b0, 12'd0);
        repeat (6) step();
        check("arcs_q_empty", 32'(exp_q.size()), 32'd0);

        // Overflow: 18 corners with no pop, then push and pop together while full.
        corner_rdy = 1'b0;
        sof = 1'b1;
        step();
        sof = 1'b0;
        check("sof_clear", 32'(frame_corners), 32'd0);
        for (int i = 0; i < 18; i++) begin
            send(16'h01FF, 8'd130, 8'd100, 8'd100, 8'd20, 20'(i), (i < 16), S1);
        end
        repeat (4) step();
        check("full_ovf", 32'(overflow_cnt), 32'd2);
        check("full_frame", 32'(frame_corners), 32'd18);
        check("full_vld", 32'(corner_vld), 32'd1);
        check("full_head_stable", 32'(corner_xy), 32'd0);
        send(16'h01FF, 8'd130, 8'd100, 8'd100, 8'd20, 20'd100, 1'b1, S1);
        step(); step();
        corner_rdy = 1'b1;
        step();
        corner_rdy = 1'b0;
        check("pushpop_ovf", 32'(overflow_cnt), 32'd2);
        check("pushpop_frame", 32'(frame_corners), 32'd19);
        corner_rdy = 1'b1;
        repeat (20) step();
        check("full_q_empty", 32'(exp_q.size()), 32'd0);
        check("full_drained", 32'(corner_vld), 32'd0);

        // ce toggling: push only on the third ce=1 edge after the sample, with sof on that edge.
        send(16'h01FF, 8'd130, 8'd100, 8'd100, 8'd20, 20'h00777, 1'b1, S1);
        ce = 1'b0; step();
        ce = 1'b1; step();
        ce = 1'b0; step();
        ce = 1'b1; step();
        check("ce_no_push_a", 32'(corner_vld), 32'd0);
        ce = 1'b0; step();
        check("ce_no_push_b", 32'(corner_vld), 32'd0);
        ce = 1'b1; sof = 1'b1; step();
        sof = 1'b0;
        check("ce_push", 32'(corner_vld), 32'd1);
        check("sof_corner", 32'(frame_corners), 32'd1);
        step();

        // Reset with 5 queued and 2 in flight.
        corner_rdy = 1'b0;
        for (int i = 0; i < 5; i++) begin
            send(16'h01FF, 8'd130, 8'd100, 8'd100, 8'd20, 20'(32'h200 + i), 1'b1, S1);
        end
        repeat (4) step();
        check("pre_rst_vld", 32'(corner_vld), 32'd1);
        send(16'h01FF, 8'd130, 8'd100, 8'd100, 8'd20, 20'h00300, 1'b1, S1);
        send(16'h01FF, 8'd130, 8'd100, 8'd100, 8'd20, 20'h00301, 1'b1, S1);
        rst_n = 1'b0;
        #1;
        check("async_rst_vld", 32'(corner_vld), 32'd0);
        check("async_rst_frame", 32'(frame_corners), 32'd0);
        check("async_rst_ovf", 32'(overflow_cnt), 32'd0);
        check("async_rst_xy", 32'(corner_xy), 32'd0);
        exp_q.delete();
        repeat (2) step();
        rst_n = 1'b1;
        ce    = 1'b1;
        repeat (6) step();
        check("no_stale_push", 32'(corner_vld), 32'd0);
        corner_rdy = 1'b1;
        send(16'hF01F, 8'd50, 8'd100, 8'd100, 8'd20, 20'h0ABCD, 1'b1, S2);
        step(); step();
        check("post_rst_early", 32'(corner_vld), 32'd0);
        step();
        check("post_rst_vld", 32'(corner_vld), 32'd1);
        repeat (3) step();
        check("final_q_empty", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/fast_corner_detect.md
FAST_CORNER_DETECT -- requirements
Module: fast_corner_detect

Interface
REQ-001 SHALL have parameter PIXEL_WIDTH, default 8, meaning the pixel bit width.
REQ-002 SHALL have parameter ARC_LEN, default 9, meaning the minimum contiguous circle arc length that marks a corner.
REQ-003 SHALL have parameter FIFO_DEPTH, default 16, meaning the output corner FIFO entries (power of 2).
REQ-004 SHALL have port clk, input, 1, the single clock.
REQ-005 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port ce, input, 1, global pipeline advance enable, the same enable that drives the line-buffer stage.
REQ-007 SHALL have port patch_vld, input, 1, marking the 7x7 window as valid.
REQ-008 SHALL have port circle, input, 16*PIXEL_WIDTH, the Bresenham-16 ring; slice k is ring pixel k, with k=0 at window (0,3) and k increasing clockwise.
REQ-009 SHALL have port center, input, PIXEL_WIDTH, window pixel (3,3).
REQ-010 SHALL have port threshold, input, PIXEL_WIDTH, FAST threshold t, sampled with the window.
REQ-011 SHALL have port xy_in, input, 20, the window centre coordinate as {x[9:0], y[9:0]}.
REQ-012 SHALL have port sof, input, 1, a start-of-frame pulse.
REQ-013 SHALL have port corner_vld, output, 1, asserted when the FIFO is non-empty.
REQ-014 SHALL have port corner_rdy, input, 1, the downstream pop.
REQ-015 SHALL have port corner_xy, output, 20, the head-entry coordinate.
REQ-016 SHALL have port corner_score, output, 12, the head-entry score.
REQ-017 SHALL have port frame_corners, output, 16, corners detected in the current frame.
REQ-018 SHALL have port overflow_cnt, output, 16, corners dropped because the FIFO was full.

Function
REQ-019 SHALL advance the 3-stage pipeline (classify, arc-detect, score/commit) only in cycles with ce=1, holding all stage registers when ce=0.
REQ-020 SHALL classify in stage 1 with PIXEL_WIDTH+2 bit arithmetic, without wrap:
- bright[k] = p_k > center+t
- dark[k] = p_k < center-t
- when center < t, all dark[k] are 0.
REQ-021 SHALL, in stage 2, flag a corner when bright or dark contains ARC_LEN or more circularly contiguous ones, including runs wrapping from k=15 to k=0.
REQ-022 SHALL, in stage 3, compute the score as the sum over k of max(|p_k-center|-t, 0), saturating at 4095.
REQ-023 SHALL have a latency of exactly 3 ce-cycles from a patch_vld=1 sample to the FIFO push; the stage valid bit follows patch_vld, and xy_in is carried alongside.
REQ-024 SHALL push {xy, score} to the FIFO when stage 3 is valid, corner is 1 and ce=1.
REQ-025 SHALL pop the FIFO on corner_vld & corner_rdy, independent of ce.
REQ-026 SHALL, on a push while the FIFO is full with no pop in the same cycle, drop the entry and increment overflow_cnt, saturating at 0xFFFF.
REQ-027 SHALL, on a push and pop in the same cycle while full, accept both; occupancy stays unchanged and nothing is dropped.
REQ-028 SHALL, on a pop while empty, have no effect.
REQ-029 SHALL increment frame_corners once per accepted or dropped corner, saturating at 0xFFFF.
REQ-030 SHALL clear frame_corners on sof; when sof coincides with a corner, frame_corners becomes 1.
REQ-031 SHALL keep corner_xy/corner_score stable while corner_vld=1 and corner_rdy=0.

Reset
REQ-032 SHALL, on rst_n=0 and asynchronously, clear:
- all stage valid bits
- FIFO pointers and occupancy
- frame_corners and overflow_cnt
- corner_vld, corner_xy and corner_score (to 0).
REQ-033 SHALL, on reset mid-frame, discard in-flight windows and queued corners; after release, the first push occurs 3 ce-cycles after the next valid window.

Configuration
REQ-034 SHALL, when FAST_SCORE_EN is defined, compute the stage-3 score per REQ-022.
REQ-035 SHALL, when FAST_SCORE_EN is undefined, omit the score adder tree, drive corner_score to 0, and store 20-bit FIFO entries; latency stays 3.

Structure
REQ-036 SHALL take PIXEL_WIDTH default, CIRCLE_N=16, SCORE_W=12, COORD_W=20 and the ring-offset table from the shared package fast_pkg.
REQ-037 SHALL implement the FIFO as sub-module fast_corner_fifo (synchronous, registered outputs, full/empty flags).

Verification
REQ-038 SHALL check: center=100, t=20, ring k=0..8 equal to 130 and the rest 100, ce=1, xy_in=0x0A00B -> corner_vld 3 cycles later, corner_xy=0x0A00B, score=90 (0 without FAST_SCORE_EN).
REQ-039 SHALL check: a wrapped dark arc at k=12..15,0..4 equal to 50, center=100, t=20 -> corner detected; the same with only 8 pixels -> no push.
REQ-040 SHALL check: center=10, t=20, all ring pixels 0 -> no dark flags, no corner; center=250, t=20, ring=255 -> no bright flags.
REQ-041 SHALL check: corner_rdy=0 with 18 corners pushed -> 16 queued, overflow_cnt=2, frame_corners=18; then a push and pop together while full -> no drop.
REQ-042 SHALL check: ce toggled 1,0,1,0 during a corner -> push after the 3rd ce=1 cycle only; sof together with a corner -> frame_corners=1.
REQ-043 SHALL check: rst_n asserted with 5 queued and 2 in flight -> corner_vld=0 immediately, counters 0, no stale push after release.
